stopwatch_display: RTL and testbench
====================================

Name: stopwatch_display

Overview:
- Consumes the stopwatch minutes/seconds values and drives the board's 4-digit multiplexed seven-segment display in MM.SS format.
- Converts the binary values to BCD and time-multiplexes the digits.
- While adjust mode is active, blinks the field being adjusted.
- Sits downstream of the selection/adjust counter block, alongside the clock-divider outputs.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. At 100 MHz this gives 1 kHz per digit.
- CNT_W, 17: width of the refresh counter. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- minutes  input  6  binary minutes; legal range 0-59
- seconds  input  6  binary seconds; legal range 0-59
- adj  input  1  adjust mode active (asynchronous, from debounced switch)
- sel  input  1  field select in adjust mode: 1 = seconds, 0 = minutes
- twohz_clk  input  1  2 Hz square wave, used as the blink phase
- seg  output  8  active-low segments: {dp,g,f,e,d,c,b,a}
- an  output  4  active-low digit enables; an[0] is the rightmost digit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; every register clears on rst assertion.
- Reset values:
  - seg = 8'hFF (all segments off)
  - an = 4'hF (all digits off)
  - refresh counter = 0, digit index = 0
  - minute/second snapshots = 0
  - synchronizer flops = 0
- Synchronizers: adj, sel and twohz_clk each pass through a 2-flop synchronizer before use.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick asserts for one cycle when the count equals REFRESH_DIV-1.
- Digit index (2 bits): increments mod 4 on tick.
  - 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens.
- Snapshot:
  - On the tick where the digit index is 3 (the 3->0 wrap), minutes and seconds are latched into snapshot registers.
  - All four digits of a scan therefore come from one coherent sample, with no tearing across a minute rollover.
  - Snapshots also load in the first cycle after reset release.
- BCD conversion (combinational, on the snapshot):
  - tens = floor(v/10), computed with a compare chain against 50/40/30/20/10.
  - ones = v - 10*tens.
  - Both are 4 bits.
- Out-of-range values: a snapshot value of 60-63 displays as two dashes for that field (segment g only, seg = 8'hBF).
- Output register:
  - seg and an are registered.
  - They update in the cycle after the digit index changes.
  - an and seg always change in the same cycle; there is never a cycle with a new an and a stale seg.
- an encoding: one-hot-low of the index. Index 0 -> 4'b1110 ... index 3 -> 4'b0111.
- Decimal point: dp (seg[7]) = 0 (lit) on index 2 only, giving the MM.SS separator. It is 1 on all other digits.
- Blink:
  - The blank condition is: adj_s = 1 AND twohz_s = 1.
  - When blanked and sel_s = 1, digits 0-1 output seg[6:0] = 7'h7F.
  - When blanked and sel_s = 0, digits 2-3 output seg[6:0] = 7'h7F.
  - The unselected field is always shown.
  - an continues to scan during blanking, and dp is unaffected.
- Adjust mode off: with adj_s = 0, no blanking occurs regardless of twohz_clk or sel.
- Leading zeros: displayed (e.g. 5 s shows "00.05").
- Input changes mid-scan: have no effect until the next snapshot.
- Reset mid-scan: outputs immediately return to their reset values. Scanning restarts at index 0 after rst deasserts, and the first tick occurs REFRESH_DIV cycles later.

Decomposition:
- Shared package holds:
  - Seven-segment constants: SEG_BLANK = 7'h7F, SEG_DASH = 7'h3F, and the digit patterns 0-9.
  - Digit index localparams: DIG_SEC_ONES, DIG_SEC_TENS, DIG_MIN_ONES, DIG_MIN_TENS.
- Sub-module seg7_decode: purely combinational, 4-bit BCD in -> 7-bit active-low pattern out. Non-decimal codes 10-15 map to SEG_BLANK.
- A 2-flop synchronizer sub-module may be reused if the codebase has one; otherwise inline it.

Test Plan (simulate with REFRESH_DIV=4):
- Reset check: reset, then minutes=0, seconds=0. Expect the scan sequence an = E,D,B,7 with seg[6:0] = 7'h40 ("0") on every digit, seg[7] = 0 only while an = B, and each digit held 4 cycles.
- Normal display: minutes=12, seconds=34, adj=0. Expect per-digit seg[6:0] of an=E "4" (7'h19), an=D "3" (7'h30), an=B "2" (7'h24), an=7 "1" (7'h79).
- Seconds blink: adj=1, sel=1, twohz_clk held 1 for more than 3 cycles. Expect digits 0-1 seg[6:0] = 7'h7F and digits 2-3 showing "12". With twohz_clk=0, all four digits are shown.
- Minutes blink and out-of-range: adj=1, sel=0, twohz_clk=1 blanks digits 2-3. Separately, seconds=61 with adj=0 shows 7'h3F on digits 0-1.
- Snapshot coherence: change seconds 59->0 while the index is 1. The remaining digits of that scan still show the old value; the next scan shows "00".
- Reset mid-scan: assert rst while an=B. Expect an=F and seg=FF in the same cycle (asynchronous). After release, the first an=E appears within 1 cycle plus the snapshot latency.

Source files
------------

// File: rtl/stopwatch_display_pkg.sv
// Shared seven-segment constants, digit slot numbering and BCD helpers
// for the MM.SS stopwatch display.
package stopwatch_display_pkg;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  localparam logic [5:0] MAX_VAL = 6'd59;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    if (v >= 6'd50)      return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    logic [5:0] t;
    logic [5:0] r;
    t = {2'b00, bcd_tens(v)};
    r = v - t * 6'd10;
    return r[3:0];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Codes 10-15 are blanked.
module seg7_decode
  import stopwatch_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (bcd)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit MM.SS display driver with per-scan snapshot and
// adjust-mode field blinking; seg/an are registered together.
module stopwatch_display
  import stopwatch_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  input  logic       twohz_clk,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [1:0]       adj_q, sel_q, tw_q;
  logic             adj_s, sel_s, tw_s;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [1:0]       idx;
  logic             run;
  logic [5:0]       snap_min, snap_sec;
  logic [5:0]       src_min, src_sec, field;
  logic [3:0]       bcd;
  logic [6:0]       pat;
  logic             blank;
  logic [7:0]       seg_nxt;
  logic [3:0]       an_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adj_q <= 2'b00;
      sel_q <= 2'b00;
      tw_q  <= 2'b00;
    end else begin
      adj_q <= {adj_q[0], adj};
      sel_q <= {sel_q[0], sel};
      tw_q  <= {tw_q[0], twohz_clk};
    end
  end

  assign adj_s = adj_q[1];
  assign sel_s = sel_q[1];
  assign tw_s  = tw_q[1];
  assign tick  = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= DIG_SEC_ONES;
      run      <= 1'b0;
      snap_min <= 6'd0;
      snap_sec <= 6'd0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      run <= 1'b1;
      if (tick) idx <= idx + 2'd1;
      // One coherent sample per scan, taken as the last digit finishes
      if (!run || (tick && idx == DIG_MIN_TENS)) begin
        snap_min <= minutes;
        snap_sec <= seconds;
      end
    end
  end

  // Before the first snapshot lands, show the value being captured
  assign src_min = run ? snap_min : minutes;
  assign src_sec = run ? snap_sec : seconds;
  assign field   = idx[1] ? src_min : src_sec;
  assign bcd     = idx[0] ? bcd_tens(field) : bcd_ones(field);

  seg7_decode u_decode (
    .bcd     (bcd),
    .pattern (pat)
  );

  always_comb begin
    blank = adj_s & tw_s & (sel_s ? (idx <= DIG_SEC_TENS) : (idx >= DIG_MIN_ONES));
    seg_nxt = 8'hFF;
    if (blank)              seg_nxt[6:0] = SEG_BLANK;
    else if (field > MAX_VAL) seg_nxt[6:0] = SEG_DASH;
    else                    seg_nxt[6:0] = pat;
    seg_nxt[7] = (idx != DIG_MIN_ONES);
    an_nxt = ~(4'b0001 << idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 8'hFF;
      an  <= 4'hF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Randomized bench for stopwatch_display against a cycle-indexed model of
// what each digit should show, built from recorded input history.
module tb_stopwatch_display;

  localparam int D = 4;
  localparam int HN = 8192;
  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] minutes = 6'd0;
  logic [5:0] seconds = 6'd0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic       twohz_clk = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;

  int tests = 0;
  int fails = 0;
  int k = 0;

  logic [5:0] h_min [HN];
  logic [5:0] h_sec [HN];
  logic       h_adj [HN];
  logic       h_sel [HN];
  logic       h_tw  [HN];

  stopwatch_display #(.REFRESH_DIV(D), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .minutes   (minutes),
    .seconds   (seconds),
    .adj       (adj),
    .sel       (sel),
    .twohz_clk (twohz_clk),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  // k counts rising edges since reset release; inputs seen at edge k are kept
  always @(posedge clk) begin
    if (!rst && k < HN - 2) begin
      k = k + 1;
      h_min[k] = minutes;
      h_sec[k] = seconds;
      h_adj[k] = adj;
      h_sel[k] = sel;
      h_tw[k]  = twohz_clk;
    end
  end

  // Expected {seg,an} just after edge kk
  function automatic logic [11:0] model(input int kk);
    int idx, src, v, d;
    logic a_s, s_s, t_s;
    logic [7:0] sg;
    logic [3:0] a;
    if (kk < 1) return {8'hFF, 4'hF};
    idx = ((kk - 1) / D) % 4;
    src = ((kk - 1) / (4 * D)) * 4 * D;
    if (src < 1) src = 1;
    v = (idx >= 2) ? int'(h_min[src]) : int'(h_sec[src]);
    d = (idx % 2 == 1) ? v / 10 : v % 10;
    sg = 8'hFF;
    sg[6:0] = (v >= 60) ? 7'h3F : PAT[d];
    a_s = (kk >= 3) ? h_adj[kk - 2] : 1'b0;
    s_s = (kk >= 3) ? h_sel[kk - 2] : 1'b0;
    t_s = (kk >= 3) ? h_tw[kk - 2]  : 1'b0;
    if (a_s && t_s && (s_s ? (idx < 2) : (idx >= 2))) sg[6:0] = 7'h7F;
    sg[7] = (idx == 2) ? 1'b0 : 1'b1;
    a = 4'hF;
    a[idx] = 1'b0;
    return {sg, a};
  endfunction

  task automatic test_reset();
    logic [11:0] e;
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    #1;
    tests++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      fails++;
      $display("FAIL reset_vals seg=%h an=%h expected seg=ff an=f", seg, an);
    end
    minutes = 6'd0;
    seconds = 6'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4 * D + 4; i++) begin
      @(negedge clk);
      e = model(k);
      tests++;
      if ({seg, an} !== e) begin
        fails++;
        $display("FAIL reset_scan k=%0d seg=%h an=%h expected seg=%h an=%h", k, seg, an, e[11:4], e[3:0]);
      end
    end
  endtask

  task automatic test_normal();
    logic [11:0] e;
    minutes = 6'd12;
    seconds = 6'd34;
    adj = 1'b0;
    for (int i = 0; i < 12 * D; i++) begin
      @(negedge clk);
      e = model(k);
      tests++;
      if ({seg, an} !== e) begin
        fails++;
        $display("FAIL normal k=%0d seg=%h an=%h expected seg=%h an=%h", k, seg, an, e[11:4], e[3:0]);
      end
      if (i % (4 * D) == 4 * D - 1) begin
        minutes = 6'($urandom_range(0, 59));
        seconds = 6'($urandom_range(0, 59));
      end
    end
  endtask

  task automatic test_sec_blink();
    logic [11:0] e;
    minutes = 6'd12;
    seconds = 6'd34;
    adj = 1'b1;
    sel = 1'b1;
    twohz_clk = 1'b1;
    for (int i = 0; i < 14 * D; i++) begin
      @(negedge clk);
      e = model(k);
      tests++;
      if ({seg, an} !== e) begin
        fails++;
        $display("FAIL sec_blink k=%0d seg=%h an=%h expected seg=%h an=%h", k, seg, an, e[11:4], e[3:0]);
      end
      if (i == 8 * D) twohz_clk = 1'b0;
    end
  endtask

  task automatic test_min_blink_oor();
    logic [11:0] e;
    adj = 1'b1;
    sel = 1'b0;
    twohz_clk = 1'b1;
    for (int i = 0; i < 16 * D; i++) begin
      @(negedge clk);
      e = model(k);
      tests++;
      if ({seg, an} !== e) begin
        fails++;
        $display("FAIL min_blink_oor k=%0d seg=%h an=%h expected seg=%h an=%h", k, seg, an, e[11:4], e[3:0]);
      end
      if (i == 6 * D) begin
        adj = 1'b0;
        seconds = 6'd61;
      end
      if (i == 11 * D) begin
        minutes = 6'($urandom_range(60, 63));
        seconds = 6'($urandom_range(0, 59));
      end
    end
  endtask

  task automatic test_coherence();
    logic [11:0] e;
    int guard;
    adj = 1'b0;
    minutes = 6'd7;
    seconds = 6'd59;
    repeat (9 * D) @(negedge clk);
    guard = 0;
    while (an !== 4'hD && guard < 8 * D) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (an !== 4'hD) begin
      fails++;
      $display("FAIL coherence_wait an=%h expected d", an);
    end
    seconds = 6'd0;
    @(negedge clk);
    tests++;
    if ({an, seg[6:0]} !== {4'hD, 7'h12}) begin
      fails++;
      $display("FAIL coherence_hold an=%h seg=%h expected an=d seg[6:0]=12", an, seg[6:0]);
    end
    for (int i = 0; i < 10 * D; i++) begin
      @(negedge clk);
      e = model(k);
      tests++;
      if ({seg, an} !== e) begin
        fails++;
        $display("FAIL coherence k=%0d seg=%h an=%h expected seg=%h an=%h", k, seg, an, e[11:4], e[3:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      e = model(k);
      tests++;
      if ({seg, an} !== e) begin
        fails++;
        $display("FAIL random k=%0d seg=%h an=%h expected seg=%h an=%h", k, seg, an, e[11:4], e[3:0]);
      end
      if ($urandom_range(0, 7) == 0) begin
        minutes = 6'($urandom_range(0, 63));
        seconds = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 15) == 0) adj = ~adj;
      if ($urandom_range(0, 15) == 0) sel = ~sel;
      if ($urandom_range(0, 5) == 0)  twohz_clk = ~twohz_clk;
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    int guard;
    guard = 0;
    while (an !== 4'hB && guard < 8 * D) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (an !== 4'hB) begin
      fails++;
      $display("FAIL reset_mid_wait an=%h expected b", an);
    end
    #2;
    rst = 1'b1;
    k = 0;
    #1;
    tests++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      fails++;
      $display("FAIL reset_mid_async seg=%h an=%h expected seg=ff an=f", seg, an);
    end
    minutes = 6'($urandom_range(0, 59));
    seconds = 6'($urandom_range(0, 59));
    adj = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10 * D; i++) begin
      @(negedge clk);
      e = model(k);
      tests++;
      if ({seg, an} !== e) begin
        fails++;
        $display("FAIL reset_mid_scan k=%0d seg=%h an=%h expected seg=%h an=%h", k, seg, an, e[11:4], e[3:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_normal();
    test_sec_blink();
    test_min_blink_oor();
    test_coherence();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
